// File: rtl/ray_gen.sv
// Primary-ray generator: walks a WIDTH x HEIGHT frame in raster order and emits one
// (origin, direction) ray per pixel, forming directions incrementally with adders only.
module ray_gen #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int unsigned YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic                          i_start,
    input  logic signed [2:0][31:0]       i_eye,
    input  logic signed [2:0][31:0]       i_dir00,
    input  logic signed [2:0][31:0]       i_du,
    input  logic signed [2:0][31:0]       i_dv,
    output logic signed [1:0][2:0][31:0]  o_ray,
    output logic [XW-1:0]                 o_px_x,
    output logic [YW-1:0]                 o_px_y,
    output logic                          o_last,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_overflow
);

    localparam logic [XW-1:0] X_MAX    = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(HEIGHT - 1);
    localparam logic          ONE_COL  = (WIDTH == 1);
    localparam logic          ONE_PIX  = (WIDTH == 1) && (HEIGHT == 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e state_q, state_d;

    logic [2:0][31:0] eye_q, eye_d;
    logic [2:0][31:0] du_q, du_d;
    logic [2:0][31:0] dv_q, dv_d;
    logic [2:0][31:0] dir_q, dir_d;
    logic [2:0][31:0] row_dir_q, row_dir_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic [2:0][31:0] step_x, step_y;
    logic [2:0]       ovf_x, ovf_y;
    logic [XW-1:0]    x_inc;
    logic [YW-1:0]    y_inc;
    logic             xfer;

    assign xfer  = (state_q == StRun) && i_ready;
    assign x_inc = x_q + XW'(1);
    assign y_inc = y_q + YW'(1);

    // Signed overflow: operands share a sign and the wrapped sum does not.
    always_comb begin
        step_x = '0;
        step_y = '0;
        ovf_x  = '0;
        ovf_y  = '0;
        for (int i = 0; i < 3; i++) begin
            step_x[i] = dir_q[i] + du_q[i];
            step_y[i] = row_dir_q[i] + dv_q[i];
            ovf_x[i]  = (dir_q[i][31] == du_q[i][31]) && (step_x[i][31] != dir_q[i][31]);
            ovf_y[i]  = (row_dir_q[i][31] == dv_q[i][31]) && (step_y[i][31] != row_dir_q[i][31]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_start) state_d = StRun;
            StRun:   if (xfer && last_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        eye_d     = eye_q;
        du_d      = du_q;
        dv_d      = dv_q;
        dir_d     = dir_q;
        row_dir_d = row_dir_q;
        x_d       = x_q;
        y_d       = y_q;
        last_d    = last_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    eye_d     = i_eye;
                    du_d      = i_du;
                    dv_d      = i_dv;
                    dir_d     = i_dir00;
                    row_dir_d = i_dir00;
                    x_d       = '0;
                    y_d       = '0;
                    ovf_d     = 1'b0;
                    last_d    = ONE_PIX;
                end
            end
            StRun: begin
                if (xfer) begin
                    if (last_q) begin
                        done_d = 1'b1;
                        last_d = 1'b0;
                    end else if (x_q == X_MAX) begin
                        x_d       = '0;
                        y_d       = y_inc;
                        row_dir_d = step_y;
                        dir_d     = step_y;
                        ovf_d     = ovf_q | (|ovf_y);
                        last_d    = ONE_COL && (y_inc == Y_MAX);
                    end else begin
                        x_d    = x_inc;
                        dir_d  = step_x;
                        ovf_d  = ovf_q | (|ovf_x);
                        last_d = (x_inc == X_MAX) && (y_q == Y_MAX);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            eye_q     <= '0;
            du_q      <= '0;
            dv_q      <= '0;
            dir_q     <= '0;
            row_dir_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            eye_q     <= eye_d;
            du_q      <= du_d;
            dv_q      <= dv_d;
            dir_q     <= dir_d;
            row_dir_q <= row_dir_d;
            x_q       <= x_d;
            y_q       <= y_d;
            last_q    <= last_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        o_valid    = (state_q == StRun);
        o_busy     = (state_q == StRun);
        o_done     = done_q;
        o_overflow = ovf_q;
        o_last     = last_q;
        o_ray[1]   = eye_q;
        o_ray[0]   = dir_q;
        o_px_x     = x_q;
        o_px_y     = y_q;
    end

endmodule

// File: tb/tb_ray_gen.sv
// Directed bench for ray_gen: 4x2, 1x3 and 2x2 frames from a shared stimulus bus,
// checked against hand-computed ray tables.
module tb_ray_gen;

    logic clk = 1'b0;
    logic rstn;
    logic start_a, start_b, start_c;
    logic ready;
    logic [2:0][31:0] eye, dir00, du, dv;

    logic [1:0][2:0][31:0] ray_a, ray_b, ray_c;
    logic [1:0] x_a;
    logic [0:0] y_a;
    logic [0:0] x_b;
    logic [1:0] y_b;
    logic [0:0] x_c, y_c;
    logic last_a, valid_a, busy_a, done_a, ovf_a;
    logic last_b, valid_b, busy_b, done_b, ovf_b;
    logic last_c, valid_c, busy_c, done_c, ovf_c;

    localparam logic [2:0][31:0] EYE0 = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000};

    typedef struct {
        logic [3:0]  x;
        logic [3:0]  y;
        logic [31:0] dx;
        logic [31:0] dy;
        logic [31:0] dz;
        logic        last;
    } vec_t;

    vec_t va[8];
    vec_t vb[3];
    vec_t vc[4];
    logic vc_ovf[4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ray_gen #(.WIDTH(4), .HEIGHT(2)) dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_start(start_a), .i_eye(eye), .i_dir00(dir00),
        .i_du(du), .i_dv(dv), .o_ray(ray_a), .o_px_x(x_a), .o_px_y(y_a), .o_last(last_a),
        .o_valid(valid_a), .i_ready(ready), .o_busy(busy_a), .o_done(done_a),
        .o_overflow(ovf_a)
    );

    ray_gen #(.WIDTH(1), .HEIGHT(3)) dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_start(start_b), .i_eye(eye), .i_dir00(dir00),
        .i_du(du), .i_dv(dv), .o_ray(ray_b), .o_px_x(x_b), .o_px_y(y_b), .o_last(last_b),
        .o_valid(valid_b), .i_ready(ready), .o_busy(busy_b), .o_done(done_b),
        .o_overflow(ovf_b)
    );

    ray_gen #(.WIDTH(2), .HEIGHT(2)) dut_c (
        .i_clk(clk), .i_rstn(rstn), .i_start(start_c), .i_eye(eye), .i_dir00(dir00),
        .i_du(du), .i_dv(dv), .o_ray(ray_c), .o_px_x(x_c), .o_px_y(y_c), .o_last(last_c),
        .o_valid(valid_c), .i_ready(ready), .o_busy(busy_c), .o_done(done_c),
        .o_overflow(ovf_c)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v, input logic [1:0][2:0][31:0] ray,
                             input logic [3:0] px, input logic [3:0] py, input logic last,
                             input logic valid, input logic [2:0][31:0] eye_exp);
        check({tag, "_valid"}, valid, 1'b1);
        check({tag, "_px_x"}, px, v.x);
        check({tag, "_px_y"}, py, v.y);
        check({tag, "_dir_x"}, ray[0][0], v.dx);
        check({tag, "_dir_y"}, ray[0][1], v.dy);
        check({tag, "_dir_z"}, ray[0][2], v.dz);
        check({tag, "_eye"}, ray[1], eye_exp);
        check({tag, "_last"}, last, v.last);
    endtask

    // Returns at 1 time unit after the edge that opened the first RUN cycle.
    task automatic pulse_start(input int which);
        @(posedge clk);
        #1;
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int  idx;
        int  cyc;
        logic xfer;
        logic seen;

        va[0] = '{x: 0, y: 0, dx: 32'h0000_0000, dy: 32'h0000_0000, dz: 32'hFFFF_0000, last: 0};
        va[1] = '{x: 1, y: 0, dx: 32'h0000_4000, dy: 32'h0000_0000, dz: 32'hFFFF_0000, last: 0};
        va[2] = '{x: 2, y: 0, dx: 32'h0000_8000, dy: 32'h0000_0000, dz: 32'hFFFF_0000, last: 0};
        va[3] = '{x: 3, y: 0, dx: 32'h0000_C000, dy: 32'h0000_0000, dz: 32'hFFFF_0000, last: 0};
        va[4] = '{x: 0, y: 1, dx: 32'h0000_0000, dy: 32'h0000_4000, dz: 32'hFFFF_0000, last: 0};
        va[5] = '{x: 1, y: 1, dx: 32'h0000_4000, dy: 32'h0000_4000, dz: 32'hFFFF_0000, last: 0};
        va[6] = '{x: 2, y: 1, dx: 32'h0000_8000, dy: 32'h0000_4000, dz: 32'hFFFF_0000, last: 0};
        va[7] = '{x: 3, y: 1, dx: 32'h0000_C000, dy: 32'h0000_4000, dz: 32'hFFFF_0000, last: 1};

        vb[0] = '{x: 0, y: 0, dx: 32'h0, dy: 32'h0000_0000, dz: 32'hFFFF_0000, last: 0};
        vb[1] = '{x: 0, y: 1, dx: 32'h0, dy: 32'h0000_4000, dz: 32'hFFFF_0000, last: 0};
        vb[2] = '{x: 0, y: 2, dx: 32'h0, dy: 32'h0000_8000, dz: 32'hFFFF_0000, last: 1};

        vc[0] = '{x: 0, y: 0, dx: 32'h7FFF_0000, dy: 32'h0000_0000, dz: 32'h0, last: 0};
        vc[1] = '{x: 1, y: 0, dx: 32'h8001_0000, dy: 32'h0000_0000, dz: 32'h0, last: 0};
        vc[2] = '{x: 0, y: 1, dx: 32'h7FFF_0000, dy: 32'h0001_0000, dz: 32'h0, last: 0};
        vc[3] = '{x: 1, y: 1, dx: 32'h8001_0000, dy: 32'h0001_0000, dz: 32'h0, last: 1};
        vc_ovf[0] = 1'b0;
        vc_ovf[1] = 1'b1;
        vc_ovf[2] = 1'b1;
        vc_ovf[3] = 1'b1;

        rstn    = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        ready   = 1'b1;
        eye     = EYE0;
        dir00   = {32'hFFFF_0000, 32'h0, 32'h0};
        du      = {32'h0, 32'h0, 32'h0000_4000};
        dv      = {32'h0, 32'h0000_4000, 32'h0};
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        @(negedge clk);
        check("rst_valid", {valid_a, valid_b, valid_c}, 3'b000);
        check("rst_busy", {busy_a, busy_b, busy_c}, 3'b000);
        check("rst_flags", {done_a, ovf_a, last_a}, 3'b000);
        check("rst_ray", ray_a, 192'h0);
        check("rst_px", {x_a, y_a}, 3'b000);

        // 4x2 frame, continuous ready.
        pulse_start(0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_vec("a1", va[i], ray_a, x_a, y_a, last_a, valid_a, EYE0);
            check("a1_busy", busy_a, 1'b1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("a1_end", {valid_a, busy_a, done_a}, 3'b001);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("a1_done_clr", done_a, 1'b0);

        // Same frame with random stalls, a mid-frame start and config churn.
        pulse_start(0);
        eye   = '1;
        dir00 = '1;
        du    = '1;
        dv    = '1;
        idx   = 0;
        cyc   = 0;
        while (idx < 8 && cyc < 200) begin
            ready   = (cyc % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            start_a = (cyc == 4);
            @(negedge clk);
            check_vec("a2", va[idx], ray_a, x_a, y_a, last_a, valid_a, EYE0);
            xfer = valid_a && ready;
            @(posedge clk);
            #1;
            if (xfer) idx++;
            cyc++;
        end
        start_a = 1'b0;
        ready   = 1'b1;
        check("a2_count", idx, 8);
        @(negedge clk);
        check("a2_end", {valid_a, done_a}, 2'b01);

        // 1x3 frame: every transfer is a row advance.
        eye   = EYE0;
        dir00 = {32'hFFFF_0000, 32'h0, 32'h0};
        du    = {32'h0, 32'h0, 32'h0000_4000};
        dv    = {32'h0, 32'h0000_4000, 32'h0};
        pulse_start(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_vec("b", vb[i], ray_b, x_b, y_b, last_b, valid_b, EYE0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("b_end", {valid_b, done_b}, 2'b01);

        // 2x2 frame with a wrapping x-step.
        dir00 = {32'h0, 32'h0, 32'h7FFF_0000};
        du    = {32'h0, 32'h0, 32'h0002_0000};
        dv    = {32'h0, 32'h0001_0000, 32'h0};
        pulse_start(2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_vec("c", vc[i], ray_c, x_c, y_c, last_c, valid_c, EYE0);
            check("c_ovf", ovf_c, vc_ovf[i]);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("c_end", {valid_c, done_c, ovf_c}, 3'b011);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("c_ovf_hold", {done_c, ovf_c}, 2'b01);

        dir00 = {32'h0, 32'h0, 32'h0001_0000};
        du    = {32'h0, 32'h0, 32'h0001_0000};
        pulse_start(2);
        @(negedge clk);
        check("c2_ovf_clr", ovf_c, 1'b0);
        check("c2_dir_x", ray_c[0][0], 32'h0001_0000);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            seen = done_c;
        end
        check("c2_done", seen, 1'b1);

        // Reset in the middle of a 4x2 frame, then a fresh start.
        dir00 = {32'hFFFF_0000, 32'h0, 32'h0};
        du    = {32'h0, 32'h0, 32'h0000_4000};
        dv    = {32'h0, 32'h0000_4000, 32'h0};
        pulse_start(0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("r_ctl", {valid_a, busy_a, done_a, ovf_a, last_a}, 5'b00000);
        check("r_ray", ray_a, 192'h0);
        check("r_px", {x_a, y_a}, 3'b000);
        pulse_start(0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_vec("r", va[i], ray_a, x_a, y_a, last_a, valid_a, EYE0);
            @(posedge clk);
            #1;
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = done_a;
            @(posedge clk);
            #1;
        end
        check("r_done", seen, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
